horner_frame_sched: RTL and testbench



---
 rtl/horner_sched_pkg.sv | 28 ++
 rtl/horner_frame_sched_if.sv | 27 ++
 rtl/horner_lane_coeff_cnt.sv | 56 +++++
 rtl/horner_frame_sched.sv | 137 +++++++++++++
 tb/tb_horner_frame_sched.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/horner_sched_pkg.sv
// Shared types and default geometry for the Horner frame sequencer.
package horner_sched_pkg;

    localparam int ORDER       = 10;
    localparam int LANES       = 16;
    localparam int NUM_BATCHES = 2;
    localparam int PIPE_LAT    = 4;
    localparam int CH_W        = 5;
    localparam int COEFF_W     = 4;
    localparam int LANE_W      = 4;
    localparam int DRAIN_W     = 3;
    localparam int NUM_CH      = NUM_BATCHES * LANES;

    typedef enum logic [2:0] {
        IDLE,
        ITER,
        DRAIN,
        WB,
        DONE
    } state_e;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] one;
        one = {{(NUM_CH-1){1'b0}}, 1'b1};
        return one << ch;
    endfunction

endpackage

// File: rtl/horner_frame_sched_if.sv
// Frame-request and datapath-control bundle between a requester and the sequencer.
interface horner_frame_sched_if;
    import horner_sched_pkg::*;

    logic               srdyi;
    logic [COEFF_W-1:0] coeff_sel;
    logic [CH_W-1:0]    channel_select;
    logic               sum_rst;
    logic               sum_en;
    logic [NUM_CH-1:0]  enableRegControl;
    logic               srdyo;
    logic               busy;
    logic               overrun;

    modport master (
        output srdyi,
        input  coeff_sel, channel_select, sum_rst, sum_en,
        input  enableRegControl, srdyo, busy, overrun
    );

    modport slave (
        input  srdyi,
        output coeff_sel, channel_select, sum_rst, sum_en,
        output enableRegControl, srdyo, busy, overrun
    );

endinterface

// File: rtl/horner_lane_coeff_cnt.sv
// Lane counter with wrap plus coefficient down-counter; shared by the
// iteration and write-back phases.
module horner_lane_coeff_cnt #(
    parameter int ORDER = horner_sched_pkg::ORDER,
    parameter int LANES = horner_sched_pkg::LANES
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  load_i,
    input  logic                                  lane_step_i,
    input  logic                                  coeff_step_i,
    output logic [horner_sched_pkg::LANE_W-1:0]   lane_o,
    output logic [horner_sched_pkg::COEFF_W-1:0]  coeff_o,
    output logic                                  last_lane_o,
    output logic                                  last_coeff_o
);
    import horner_sched_pkg::*;

    logic [LANE_W-1:0]  lane_q,  lane_d;
    logic [COEFF_W-1:0] coeff_q, coeff_d;

    assign last_lane_o  = (lane_q == LANE_W'(LANES - 1));
    assign last_coeff_o = (coeff_q == '0);
    assign lane_o       = lane_q;
    assign coeff_o      = coeff_q;

    // coeff saturates at 0 so the final wrap leaves it parked for DRAIN/WB
    always_comb begin
        lane_d  = lane_q;
        coeff_d = coeff_q;
        if (load_i) begin
            lane_d  = '0;
            coeff_d = COEFF_W'(ORDER);
        end else if (lane_step_i) begin
            if (last_lane_o) begin
                lane_d = '0;
                if (coeff_step_i && !last_coeff_o) begin
                    coeff_d = coeff_q - 1'b1;
                end
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            coeff_q <= '0;
        end else begin
            lane_q  <= lane_d;
            coeff_q <= coeff_d;
        end
    end

endmodule

// File: rtl/horner_frame_sched.sv
// Frame sequencer for the shared 32-channel Horner datapath: iterate, drain,
// write back per batch, with a one-deep start queue and sticky overrun flag.
module horner_frame_sched #(
    parameter int ORDER       = horner_sched_pkg::ORDER,
    parameter int LANES       = horner_sched_pkg::LANES,
    parameter int NUM_BATCHES = horner_sched_pkg::NUM_BATCHES,
    parameter int PIPE_LAT    = horner_sched_pkg::PIPE_LAT
) (
    input  logic                 clk,
    input  logic                 GlobalReset,
    horner_frame_sched_if.slave  bus
);
    import horner_sched_pkg::*;

    state_e              state_q, state_d;
    logic                batch_q, batch_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;

    logic                cnt_load, lane_step, coeff_step;
    logic [LANE_W-1:0]   lane;
    logic [COEFF_W-1:0]  coeff;
    logic                last_lane, last_coeff;
    logic                in_frame;

    horner_lane_coeff_cnt #(
        .ORDER (ORDER),
        .LANES (LANES)
    ) u_cnt (
        .clk          (clk),
        .rst          (GlobalReset),
        .load_i       (cnt_load),
        .lane_step_i  (lane_step),
        .coeff_step_i (coeff_step),
        .lane_o       (lane),
        .coeff_o      (coeff),
        .last_lane_o  (last_lane),
        .last_coeff_o (last_coeff)
    );

    assign in_frame = (state_q == ITER) || (state_q == DRAIN) || (state_q == WB);

    always_comb begin
        state_d    = state_q;
        batch_d    = batch_q;
        drain_d    = drain_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        cnt_load   = 1'b0;
        lane_step  = 1'b0;
        coeff_step = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.srdyi) begin
                    state_d  = ITER;
                    batch_d  = 1'b0;
                    cnt_load = 1'b1;
                end
            end
            ITER: begin
                lane_step  = 1'b1;
                coeff_step = 1'b1;
                if (last_lane && last_coeff) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_W'(PIPE_LAT - 1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = WB;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            WB: begin
                lane_step = 1'b1;
                if (last_lane) begin
                    if (batch_q != 1'(NUM_BATCHES - 1)) begin
                        state_d  = ITER;
                        batch_d  = batch_q + 1'b1;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (pending_q || bus.srdyi) begin
                    state_d   = ITER;
                    batch_d   = 1'b0;
                    cnt_load  = 1'b1;
                    // a fresh request alongside a queued one takes the freed slot
                    pending_d = pending_q && bus.srdyi;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_frame && bus.srdyi) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q   <= IDLE;
            batch_q   <= 1'b0;
            drain_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            batch_q   <= batch_d;
            drain_q   <= drain_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.coeff_sel        = (state_q == ITER) ? coeff : '0;
    assign bus.channel_select   = in_frame ? {batch_q, lane} : '0;
    assign bus.sum_rst          = (state_q == ITER) && (coeff == COEFF_W'(ORDER)) && (lane == '0);
    assign bus.sum_en           = (state_q == ITER) || (state_q == DRAIN);
    assign bus.enableRegControl = (state_q == WB) ? ch_onehot({batch_q, lane}) : '0;
    assign bus.srdyo            = (state_q == DONE);
    assign bus.busy             = (state_q != IDLE);
    assign bus.overrun          = overrun_q;

endmodule

// File: tb/tb_horner_frame_sched.sv
// Directed bench for horner_frame_sched: frame timing, write-back, queuing,
// overrun, async reset and DONE-coincident restart.
module tb_horner_frame_sched;

    logic clk;
    logic GlobalReset;
    int   n_tests;
    int   n_fail;

    horner_frame_sched_if bus ();

    horner_frame_sched dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Expected values as a function of frame-relative cycle r (1 = first cycle after accept).
    function automatic logic [3:0] exp_coeff(input int r);
        if (r >= 1 && r <= 176)   return 4'(10 - (r - 1) / 16);
        if (r >= 197 && r <= 372) return 4'(10 - (r - 197) / 16);
        return 4'd0;
    endfunction

    function automatic logic [4:0] exp_ch(input int r);
        if (r >= 1 && r <= 176)   return 5'((r - 1) % 16);
        if (r >= 177 && r <= 180) return 5'd0;
        if (r >= 181 && r <= 196) return 5'(r - 181);
        if (r >= 197 && r <= 372) return 5'(16 + (r - 197) % 16);
        if (r >= 373 && r <= 376) return 5'd16;
        if (r >= 377 && r <= 392) return 5'(16 + r - 377);
        return 5'd0;
    endfunction

    function automatic logic [31:0] exp_wen(input int r);
        logic [31:0] one;
        one = 32'd1;
        if (r >= 181 && r <= 196) return one << (r - 181);
        if (r >= 377 && r <= 392) return one << (r - 361);
        return 32'd0;
    endfunction

    function automatic logic exp_sum_en(input int r);
        return (r >= 1 && r <= 180) || (r >= 197 && r <= 376);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 with srdyi driven high for "cycle 0".
    task automatic start_frame();
        bus.srdyi = 1'b1;
        next_cycle();
        bus.srdyi = 1'b0;
    endtask

    task automatic test_reset();
        bus.srdyi   = 1'b0;
        GlobalReset = 1'b1;
        #12;
        n_tests++; if (bus.coeff_sel !== 4'd0) begin n_fail++; $display("FAIL reset coeff_sel got %0d want 0", bus.coeff_sel); end
        n_tests++; if (bus.channel_select !== 5'd0) begin n_fail++; $display("FAIL reset channel_select got %0d want 0", bus.channel_select); end
        n_tests++; if (bus.sum_rst !== 1'b0) begin n_fail++; $display("FAIL reset sum_rst got %b want 0", bus.sum_rst); end
        n_tests++; if (bus.sum_en !== 1'b0) begin n_fail++; $display("FAIL reset sum_en got %b want 0", bus.sum_en); end
        n_tests++; if (bus.enableRegControl !== 32'd0) begin n_fail++; $display("FAIL reset enableRegControl got %h want 0", bus.enableRegControl); end
        n_tests++; if (bus.srdyo !== 1'b0) begin n_fail++; $display("FAIL reset srdyo got %b want 0", bus.srdyo); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", bus.busy); end
        n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset overrun got %b want 0", bus.overrun); end
        GlobalReset = 1'b0;
        next_cycle();
        next_cycle();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req busy got %b want 0", bus.busy); end
    endtask

    task automatic test_iteration();
        start_frame();
        for (int r = 1; r <= 394; r++) begin
            n_tests++;
            if (bus.sum_rst !== (r == 1 || r == 197)) begin
                n_fail++; $display("FAIL iter sum_rst r=%0d got %b want %b", r, bus.sum_rst, (r == 1 || r == 197));
            end
            if (r <= 180 || (r >= 197 && r <= 376)) begin
                n_tests++;
                if (bus.coeff_sel !== exp_coeff(r)) begin
                    n_fail++; $display("FAIL iter coeff_sel r=%0d got %0d want %0d", r, bus.coeff_sel, exp_coeff(r));
                end
            end
            if (r != 393) begin
                n_tests++;
                if (bus.sum_en !== exp_sum_en(r)) begin
                    n_fail++; $display("FAIL iter sum_en r=%0d got %b want %b", r, bus.sum_en, exp_sum_en(r));
                end
            end
            n_tests++;
            if (bus.srdyo !== (r == 393)) begin
                n_fail++; $display("FAIL iter srdyo r=%0d got %b want %b", r, bus.srdyo, (r == 393));
            end
            n_tests++;
            if (bus.busy !== (r <= 393)) begin
                n_fail++; $display("FAIL iter busy r=%0d got %b want %b", r, bus.busy, (r <= 393));
            end
            next_cycle();
        end
    endtask

    task automatic test_writeback();
        start_frame();
        for (int r = 1; r <= 394; r++) begin
            n_tests++;
            if (bus.enableRegControl !== exp_wen(r)) begin
                n_fail++; $display("FAIL wb enable r=%0d got %h want %h", r, bus.enableRegControl, exp_wen(r));
            end
            if (r <= 392) begin
                n_tests++;
                if (bus.channel_select !== exp_ch(r)) begin
                    n_fail++; $display("FAIL wb channel_select r=%0d got %0d want %0d", r, bus.channel_select, exp_ch(r));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_queued();
        start_frame();
        for (int r = 1; r <= 787; r++) begin
            if (r == 393 || r == 786) begin
                n_tests++; if (bus.srdyo !== 1'b1) begin n_fail++; $display("FAIL queued srdyo r=%0d got %b want 1", r, bus.srdyo); end
            end
            if (r == 197 || r == 394 || r == 590) begin
                n_tests++; if (bus.sum_rst !== 1'b1) begin n_fail++; $display("FAIL queued sum_rst r=%0d got %b want 1", r, bus.sum_rst); end
            end
            if (r == 394) begin
                n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL queued overrun r=%0d got %b want 0", r, bus.overrun); end
                n_tests++; if (bus.coeff_sel !== 4'd10) begin n_fail++; $display("FAIL queued coeff_sel r=%0d got %0d want 10", r, bus.coeff_sel); end
            end
            if (r == 787) begin
                n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL queued busy r=%0d got %b want 0", r, bus.busy); end
            end
            bus.srdyi = (r == 50);
            next_cycle();
            bus.srdyi = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        start_frame();
        for (int r = 1; r <= 787; r++) begin
            if (r == 393 || r == 786) begin
                n_tests++; if (bus.srdyo !== 1'b1) begin n_fail++; $display("FAIL b2b srdyo r=%0d got %b want 1", r, bus.srdyo); end
            end
            if (r == 394) begin
                n_tests++; if (bus.coeff_sel !== 4'd10) begin n_fail++; $display("FAIL b2b coeff_sel got %0d want 10", bus.coeff_sel); end
                n_tests++; if (bus.channel_select !== 5'd0) begin n_fail++; $display("FAIL b2b channel_select got %0d want 0", bus.channel_select); end
                n_tests++; if (bus.sum_rst !== 1'b1) begin n_fail++; $display("FAIL b2b sum_rst got %b want 1", bus.sum_rst); end
                n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b overrun got %b want 0", bus.overrun); end
                n_tests++; if (bus.srdyo !== 1'b0) begin n_fail++; $display("FAIL b2b srdyo_after got %b want 0", bus.srdyo); end
            end
            if (r == 787) begin
                n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b busy got %b want 0", bus.busy); end
            end
            bus.srdyi = (r == 393);
            next_cycle();
            bus.srdyi = 1'b0;
        end
    endtask

    task automatic test_overrun();
        start_frame();
        for (int r = 1; r <= 800; r++) begin
            if (r == 100) begin
                n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun early got %b want 0", bus.overrun); end
            end
            if (r == 101 || r == 393 || r == 600 || r == 800) begin
                n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun sticky r=%0d got %b want 1", r, bus.overrun); end
            end
            if (r == 394) begin
                n_tests++; if (bus.sum_rst !== 1'b1) begin n_fail++; $display("FAIL overrun queued_start got %b want 1", bus.sum_rst); end
            end
            if (r == 786) begin
                n_tests++; if (bus.srdyo !== 1'b1) begin n_fail++; $display("FAIL overrun second_done got %b want 1", bus.srdyo); end
            end
            if (r == 787) begin
                n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL overrun no_third_frame busy got %b want 0", bus.busy); end
            end
            bus.srdyi = (r == 50 || r == 100);
            next_cycle();
            bus.srdyi = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        start_frame();
        for (int r = 1; r < 200; r++) next_cycle();
        n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL areset pre overrun got %b want 1", bus.overrun); end
        n_tests++; if (bus.channel_select !== 5'd19) begin n_fail++; $display("FAIL areset pre channel_select got %0d want 19", bus.channel_select); end
        #2;
        GlobalReset = 1'b1;
        #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL areset busy got %b want 0", bus.busy); end
        n_tests++; if (bus.sum_en !== 1'b0) begin n_fail++; $display("FAIL areset sum_en got %b want 0", bus.sum_en); end
        n_tests++; if (bus.coeff_sel !== 4'd0) begin n_fail++; $display("FAIL areset coeff_sel got %0d want 0", bus.coeff_sel); end
        n_tests++; if (bus.channel_select !== 5'd0) begin n_fail++; $display("FAIL areset channel_select got %0d want 0", bus.channel_select); end
        n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL areset overrun got %b want 0", bus.overrun); end
        n_tests++; if (bus.enableRegControl !== 32'd0) begin n_fail++; $display("FAIL areset enableRegControl got %h want 0", bus.enableRegControl); end
        #3;
        GlobalReset = 1'b0;
        next_cycle();
        start_frame();
        n_tests++; if (bus.sum_rst !== 1'b1) begin n_fail++; $display("FAIL restart sum_rst got %b want 1", bus.sum_rst); end
        n_tests++; if (bus.coeff_sel !== 4'd10) begin n_fail++; $display("FAIL restart coeff_sel got %0d want 10", bus.coeff_sel); end
        n_tests++; if (bus.channel_select !== 5'd0) begin n_fail++; $display("FAIL restart channel_select got %0d want 0", bus.channel_select); end
        for (int r = 1; r < 17; r++) next_cycle();
        n_tests++; if (bus.coeff_sel !== 4'd9) begin n_fail++; $display("FAIL restart coeff_sel_c17 got %0d want 9", bus.coeff_sel); end
        n_tests++; if (bus.channel_select !== 5'd0) begin n_fail++; $display("FAIL restart channel_select_c17 got %0d want 0", bus.channel_select); end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        GlobalReset = 1'b1;
        bus.srdyi   = 1'b0;
        test_reset();
        test_iteration();
        test_writeback();
        test_queued();
        test_back_to_back();
        test_overrun();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
